// File: rtl/reg_bank8.sv
// rtl/reg_bank8.sv - 8-entry register bank with one-hot write strobes, bypassed dual read ports and sticky strobe error
module reg_bank8 #(
   parameter int WIDTH    = 8,
   parameter bit R0_ZERO  = 1'b0,
   parameter bit REG_READ = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we0,
   input  logic             we1,
   input  logic             we2,
   input  logic             we3,
   input  logic             we4,
   input  logic             we5,
   input  logic             we6,
   input  logic             we7,
   input  logic [WIDTH-1:0] wdata,
   input  logic [2:0]       raddr_a,
   input  logic [2:0]       raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   input  logic             clr_err,
   output logic             onehot_err
);

   logic [7:0]       we_vec;
   logic [3:0]       strobe_cnt;
   logic [2:0]       wr_idx;
   logic             wr_legal;
   logic             wr_multi;
   logic             wr_en;

   logic [WIDTH-1:0] regs_q [8];
   logic [WIDTH-1:0] regs_d [8];
   logic             err_q;
   logic             err_d;
   logic [WIDTH-1:0] rdata_a_q;
   logic [WIDTH-1:0] rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q;
   logic [WIDTH-1:0] rdata_b_d;

   assign we_vec = {we7, we6, we5, we4, we3, we2, we1, we0};

   // Count raised strobes and locate the target; only a single strobe is a legal write
   always_comb begin
      strobe_cnt = 4'd0;
      wr_idx     = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (we_vec[i]) begin
            strobe_cnt = strobe_cnt + 4'd1;
            wr_idx     = 3'(i);
         end
      end
      wr_legal = (strobe_cnt == 4'd1);
      wr_multi = (strobe_cnt > 4'd1);
      // A lone we0 with a hard-wired zero register is legal but stores nothing
      wr_en    = wr_legal && !(R0_ZERO && (wr_idx == 3'd0));
   end

   // Next register contents: at most one register takes wdata
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_en) begin
         regs_d[wr_idx] = wdata;
      end
      if (R0_ZERO) begin
         regs_d[0] = '0;
      end
   end

   // Sticky error: a multi-hot event beats a simultaneous clear
   always_comb begin
      err_d = err_q;
      if (wr_multi) begin
         err_d = 1'b1;
      end else if (clr_err) begin
         err_d = 1'b0;
      end
   end

   // Bypassed read values: same-cycle write data forwarded, zero register overrides all
   always_comb begin
      rdata_a_d = regs_q[raddr_a];
      if (wr_legal && (wr_idx == raddr_a)) begin
         rdata_a_d = wdata;
      end
      if (R0_ZERO && (raddr_a == 3'd0)) begin
         rdata_a_d = '0;
      end

      rdata_b_d = regs_q[raddr_b];
      if (wr_legal && (wr_idx == raddr_b)) begin
         rdata_b_d = wdata;
      end
      if (R0_ZERO && (raddr_b == 3'd0)) begin
         rdata_b_d = '0;
      end
   end

   // Register file and error flag state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= regs_d[i];
         end
         err_q <= err_d;
      end
   end

   // Read-port output flops, only observed when reads are registered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   assign rdata_a    = REG_READ ? rdata_a_q : rdata_a_d;
   assign rdata_b    = REG_READ ? rdata_b_q : rdata_b_d;
   assign onehot_err = err_q;

endmodule

// File: tb/tb_reg_bank8.sv
// tb/tb_reg_bank8.sv - self-checking bench for reg_bank8 in combinational and registered/zero-reg configurations
module tb_reg_bank8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] we;
   logic [7:0] wdata;
   logic [2:0] raddr_a;
   logic [2:0] raddr_b;
   logic       clr_err;

   logic [7:0] d0_ra, d0_rb, d1_ra, d1_rb;
   logic       d0_err, d1_err;

   int checks = 0;
   int errors = 0;

   // reference state: bank 0 = plain/combinational, bank 1 = zero-reg/registered
   logic [7:0] m0 [8];
   logic [7:0] m1 [8];
   logic       e0, e1;
   logic [7:0] x1a, x1b;

   always #5 clk = ~clk;

   reg_bank8 #(.WIDTH(8), .R0_ZERO(1'b0), .REG_READ(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .we0(we[0]), .we1(we[1]), .we2(we[2]), .we3(we[3]),
      .we4(we[4]), .we5(we[5]), .we6(we[6]), .we7(we[7]),
      .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(d0_ra), .rdata_b(d0_rb), .clr_err(clr_err), .onehot_err(d0_err)
   );

   reg_bank8 #(.WIDTH(8), .R0_ZERO(1'b1), .REG_READ(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .we0(we[0]), .we1(we[1]), .we2(we[2]), .we3(we[3]),
      .we4(we[4]), .we5(we[5]), .we6(we[6]), .we7(we[7]),
      .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(d1_ra), .rdata_b(d1_rb), .clr_err(clr_err), .onehot_err(d1_err)
   );

   function automatic logic [7:0] comb0(input logic [2:0] a);
      if ($countones(we) == 1 && we[a]) return wdata;
      return m0[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m0[i] = 8'h00;
         m1[i] = 8'h00;
      end
      e0 = 1'b0; e1 = 1'b0; x1a = 8'h00; x1b = 8'h00;
   endtask

   // apply the edge rules to the model, then advance one clock
   task automatic cycle();
      int n;
      n = $countones(we);
      if (n == 1) begin
         for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
               m0[i] = wdata;
               if (i != 0) m1[i] = wdata;
            end
         end
      end
      if (n >= 2) begin
         e0 = 1'b1; e1 = 1'b1;
      end else if (clr_err) begin
         e0 = 1'b0; e1 = 1'b0;
      end
      x1a = m1[raddr_a];
      x1b = m1[raddr_b];
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; we = 8'h00; wdata = 8'h00; raddr_a = 3'd1; raddr_b = 3'd6; clr_err = 1'b0;
      model_reset();
      #3;
      checks++;
      if ({d0_ra, d0_rb, d1_ra, d1_rb, d0_err, d1_err} !== 34'h0) begin
         errors++;
         $display("FAIL reset_initial got %h %h %h %h err %b %b want all zero", d0_ra, d0_rb, d1_ra, d1_rb, d0_err, d1_err);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         we = 8'(1 << n); wdata = 8'hA5;
         cycle();
      end
      we = 8'h81; wdata = 8'h00;
      cycle();
      we = 8'h00;
      checks++;
      if (d0_err !== 1'b1 || d1_err !== 1'b1) begin
         errors++;
         $display("FAIL reset_preload_err got %b %b want 1 1", d0_err, d1_err);
      end
      checks++;
      if (d0_ra !== 8'hA5) begin
         errors++;
         $display("FAIL reset_preload_read got %h want a5", d0_ra);
      end
      // reset pulse between edges, reads must clear immediately
      reset_n = 1'b0;
      model_reset();
      for (int a = 0; a < 4; a++) begin
         raddr_a = 3'(a); raddr_b = 3'(a + 4);
         #1;
         checks++;
         if ({d0_ra, d0_rb, d1_ra, d1_rb, d0_err, d1_err} !== 34'h0) begin
            errors++;
            $display("FAIL reset_pulse addr %0d got %h %h %h %h err %b %b want all zero", a, d0_ra, d0_rb, d1_ra, d1_rb, d0_err, d1_err);
         end
      end
      reset_n = 1'b1;
      // first edge after release performs a normal write
      we = 8'h10; wdata = 8'h5A; raddr_a = 3'd4; raddr_b = 3'd5;
      #1;
      checks++;
      if (d0_ra !== 8'h5A || d0_rb !== 8'h00) begin
         errors++;
         $display("FAIL reset_release_bypass got %h %h want 5a 00", d0_ra, d0_rb);
      end
      cycle();
      we = 8'h00;
      checks++;
      if (d1_ra !== 8'h5A || d1_rb !== 8'h00 || d0_ra !== 8'h5A) begin
         errors++;
         $display("FAIL reset_release_write got d1 %h %h d0 %h want 5a 00 5a", d1_ra, d1_rb, d0_ra);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] want_a, want_b;
      for (int n = 0; n < 8; n++) begin
         we = 8'(1 << n); wdata = 8'(8'h10 + n);
         cycle();
      end
      we = 8'h00;
      for (int a = 0; a < 8; a++) begin
         raddr_a = 3'(a); raddr_b = 3'(7 - a);
         #1;
         checks++;
         if (d0_ra !== 8'(8'h10 + a) || d0_rb !== 8'(8'h17 - a)) begin
            errors++;
            $display("FAIL sweep_comb addr %0d got %h %h want %h %h", a, d0_ra, d0_rb, 8'(8'h10 + a), 8'(8'h17 - a));
         end
         cycle();
         want_a = (a == 0) ? 8'h00 : 8'(8'h10 + a);
         want_b = (a == 7) ? 8'h00 : 8'(8'h17 - a);
         checks++;
         if (d1_ra !== want_a || d1_rb !== want_b) begin
            errors++;
            $display("FAIL sweep_reg addr %0d got %h %h want %h %h", a, d1_ra, d1_rb, want_a, want_b);
         end
      end
   endtask

   task automatic test_bypass();
      we = 8'h08; wdata = 8'h3C; raddr_a = 3'd3; raddr_b = 3'd2;
      #1;
      checks++;
      if (d0_ra !== 8'h3C || d0_rb !== 8'h12) begin
         errors++;
         $display("FAIL bypass_comb got %h %h want 3c 12", d0_ra, d0_rb);
      end
      cycle();
      we = 8'h00;
      checks++;
      if (d1_ra !== 8'h3C || d1_rb !== 8'h12) begin
         errors++;
         $display("FAIL bypass_reg got %h %h want 3c 12", d1_ra, d1_rb);
      end
      // zero register wins over bypass on the registered bank
      we = 8'h01; wdata = 8'h77; raddr_a = 3'd0; raddr_b = 3'd0;
      #1;
      checks++;
      if (d0_ra !== 8'h77 || d0_rb !== 8'h77) begin
         errors++;
         $display("FAIL bypass_r0_comb got %h %h want 77 77", d0_ra, d0_rb);
      end
      cycle();
      we = 8'h00;
      checks++;
      if (d1_ra !== 8'h00 || d1_rb !== 8'h00 || d1_err !== 1'b0) begin
         errors++;
         $display("FAIL bypass_r0_reg got %h %h err %b want 00 00 0", d1_ra, d1_rb, d1_err);
      end
   endtask

   task automatic test_multihot();
      logic [7:0] old2, old5;
      old2 = m0[2]; old5 = m0[5];
      we = 8'h24; wdata = 8'hFF; raddr_a = 3'd2; raddr_b = 3'd5;
      #1;
      checks++;
      if (d0_ra !== old2 || d0_rb !== old5) begin
         errors++;
         $display("FAIL multihot_no_bypass got %h %h want %h %h", d0_ra, d0_rb, old2, old5);
      end
      cycle();
      we = 8'h00;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (d0_err !== 1'b1 || d1_err !== 1'b1) begin
            errors++;
            $display("FAIL multihot_sticky idle %0d got %b %b want 1 1", k, d0_err, d1_err);
         end
         cycle();
      end
      checks++;
      if (d0_ra !== old2 || d0_rb !== old5 || d1_ra !== m1[2] || d1_rb !== m1[5]) begin
         errors++;
         $display("FAIL multihot_keep got %h %h %h %h want %h %h %h %h", d0_ra, d0_rb, d1_ra, d1_rb, old2, old5, m1[2], m1[5]);
      end
   endtask

   task automatic test_clear_race();
      clr_err = 1'b1; we = 8'h24; wdata = 8'hEE;
      cycle();
      checks++;
      if (d0_err !== 1'b1 || d1_err !== 1'b1) begin
         errors++;
         $display("FAIL clear_race got %b %b want 1 1", d0_err, d1_err);
      end
      we = 8'h00;
      cycle();
      clr_err = 1'b0;
      checks++;
      if (d0_err !== 1'b0 || d1_err !== 1'b0) begin
         errors++;
         $display("FAIL clear_alone got %b %b want 0 0", d0_err, d1_err);
      end
   endtask

   task automatic test_random();
      int idle = 0;
      logic [7:0] ea, eb;
      for (int it = 0; it < 2000; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            we = 8'h00;
            idle++;
         end else begin
            we = 8'(1 << $urandom_range(0, 7));
         end
         wdata   = 8'($urandom);
         raddr_a = 3'($urandom);
         raddr_b = 3'($urandom);
         clr_err = ($urandom_range(0, 7) == 0);
         #1;
         ea = comb0(raddr_a);
         eb = comb0(raddr_b);
         checks++;
         if (d0_ra !== ea || d0_rb !== eb) begin
            errors++;
            if (errors < 20) $display("FAIL random_comb it %0d got %h %h want %h %h", it, d0_ra, d0_rb, ea, eb);
         end
         cycle();
         checks++;
         if (d1_ra !== x1a || d1_rb !== x1b || d0_err !== e0 || d1_err !== e1) begin
            errors++;
            if (errors < 20) $display("FAIL random_reg it %0d got %h %h err %b %b want %h %h err %b %b", it, d1_ra, d1_rb, d0_err, d1_err, x1a, x1b, e0, e1);
         end
      end
      we = 8'h00; clr_err = 1'b0;
      checks++;
      if (idle == 0) begin
         errors++;
         $display("FAIL random_idle_seen got %0d want >0", idle);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_bypass();
      test_multihot();
      test_clear_race();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
